lieat_idu_dispq: RTL and testbench

Parametrised dispatch queue for the IDU. It replaces the single-entry dispatch register with a DEPTH-entry in-order FIFO between decode and NCH execution channels, such as com, lsu and muldiv. Each entry carries a one-hot channel select and a payload. The head entry issues to exactly one channel when the hazard condition allows. Flush clears the whole queue. The block also reports occupancy and a saturating head-stall counter for performance monitoring.

---
 rtl/lieat_idu_dispq_if.sv | 39 +++
 rtl/lieat_idu_dispq.sv | 89 ++++++++
 tb/tb_lieat_idu_dispq.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lieat_idu_dispq_if.sv
// ----------------------------------------------------------------------------
// lieat_idu_dispq_if
//   Bundles the decode-side enqueue handshake, the per-channel dispatch
//   handshake, and the occupancy and stall monitor outputs of the dispatch queue.
//   master : decode / execution-channel side (drives valid, chan, payload,
//            condition, flush, disp_ready)
//   slave  : the dispatch queue itself
// ----------------------------------------------------------------------------
interface lieat_idu_dispq_if #(
  parameter int DEPTH = 4,
  parameter int NCH   = 3,
  parameter int PLW   = 32,
  parameter int CNTW  = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            id_i_valid;
  logic            id_i_ready;
  logic [NCH-1:0]  id_i_chan;
  logic [PLW-1:0]  id_i_payload;
  logic            disp_condition;
  logic            flush_req;
  logic [NCH-1:0]  disp_valid;
  logic [NCH-1:0]  disp_ready;
  logic [PLW-1:0]  disp_payload;
  logic            longi_disp;
  logic [CW-1:0]   disp_count;
  logic [CNTW-1:0] disp_stall_cnt;

  modport master (
    output id_i_valid, id_i_chan, id_i_payload, disp_condition, flush_req, disp_ready,
    input  id_i_ready, disp_valid, disp_payload, longi_disp, disp_count, disp_stall_cnt
  );

  modport slave (
    input  id_i_valid, id_i_chan, id_i_payload, disp_condition, flush_req, disp_ready,
    output id_i_ready, disp_valid, disp_payload, longi_disp, disp_count, disp_stall_cnt
  );
endinterface

// File: rtl/lieat_idu_dispq.sv
// ----------------------------------------------------------------------------
// lieat_idu_dispq
//   DEPTH-entry in-order dispatch FIFO between decode and NCH execution
//   channels. Each entry holds a one-hot channel select and a payload. The head
//   entry is offered to its channel when disp_condition is high. Flush empties
//   the queue. A saturating counter records the cycles in which a non-empty
//   queue fails to dispatch.
//   Ports:
//     clk   - clock
//     rstn  - synchronous active-low reset
//     bus   - slave side of lieat_idu_dispq_if (enqueue, dispatch, monitor)
// ----------------------------------------------------------------------------
module lieat_idu_dispq #(
  parameter int             DEPTH      = 4,
  parameter int             NCH        = 3,
  parameter int             PLW        = 32,
  parameter logic [NCH-1:0] LONGI_MASK = 3'b110,
  parameter int             CNTW       = 16
) (
  input  logic              clk,
  input  logic              rstn,
  lieat_idu_dispq_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [DEPTH-1:0][NCH-1:0] r_chan;
  logic [DEPTH-1:0][PLW-1:0] r_pay;
  logic [AW-1:0]             r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]             r_count;
  logic [CNTW-1:0]           r_stall;

  logic                      w_hv, w_deq, w_enq, w_ready;
  logic [NCH-1:0]            w_disp_valid, w_hs;

  // Head is offered only when the queue holds something, the hazard check
  // clears, and no flush is in progress.
  assign w_hv         = (r_count != '0) & bus.disp_condition & ~bus.flush_req;
  assign w_disp_valid = w_hv ? r_chan[r_rd_ptr] : '0;
  assign w_hs         = w_disp_valid & bus.disp_ready;
  assign w_deq        = |w_hs;
  // A full queue still accepts when the head leaves in the same cycle. The
  // ready signal depends on state and dispatch only, never on id_i_valid.
  assign w_ready      = ~bus.flush_req & ((r_count != FULL) | w_deq);
  assign w_enq        = bus.id_i_valid & w_ready;

  assign bus.id_i_ready     = w_ready;
  assign bus.disp_valid     = w_disp_valid;
  assign bus.disp_payload   = r_pay[r_rd_ptr];
  assign bus.longi_disp     = |(w_hs & LONGI_MASK);
  assign bus.disp_count     = r_count;
  assign bus.disp_stall_cnt = r_stall;

  // Entry storage needs no reset because the pointers and count decide which
  // entries are live. w_enq is already low during a flush.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_chan[r_wr_ptr] <= bus.id_i_chan;
      r_pay[r_wr_ptr]  <= bus.id_i_payload;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (bus.flush_req) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_deq) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(w_enq) - CW'(w_deq);
    end
  end

  // A blocked head is either a hazard (condition low) or a busy channel. Flush
  // does not clear this counter, so it survives across pipeline flushes.
  always_ff @(posedge clk) begin
    if (!rstn)
      r_stall <= '0;
    else if ((r_count != '0) & ~bus.flush_req & ~w_deq & (r_stall != '1))
      r_stall <= r_stall + 1'b1;
  end
endmodule

// File: tb/tb_lieat_idu_dispq.sv
module tb_lieat_idu_dispq;
  localparam int DEPTH = 4, NCH = 3, PLW = 32, CNTW = 4;
  localparam logic [2:0] LONGI = 3'b110;
  localparam int SMAX = 15;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  lieat_idu_dispq_if #(.DEPTH(DEPTH), .NCH(NCH), .PLW(PLW), .CNTW(CNTW)) bus ();

  lieat_idu_dispq #(.DEPTH(DEPTH), .NCH(NCH), .PLW(PLW), .LONGI_MASK(LONGI), .CNTW(CNTW))
    dut (.clk(clk), .rstn(rstn), .bus(bus));

  always @(negedge clk)
    if (rstn && bus.id_i_valid)
      assert ($onehot(bus.id_i_chan)) else $error("protocol: id_i_chan not one-hot");

  // Reference model: the queue is a list of entries, and the stall counter is a plain integer.
  typedef struct packed { logic [2:0] chan; logic [31:0] pl; } ent_t;
  ent_t        m_q[$];
  int unsigned m_stall;
  logic        e_ready, e_deq, e_longi;
  logic [2:0]  e_valid;
  logic [31:0] e_pay;
  int          n_chk = 0, n_pass = 0;

  task automatic model_eval();
    e_valid = (m_q.size() != 0 && bus.disp_condition && !bus.flush_req) ? m_q[0].chan : 3'b000;
    e_deq   = |(e_valid & bus.disp_ready);
    e_longi = |(e_valid & bus.disp_ready & LONGI);
    e_ready = !bus.flush_req && (m_q.size() < DEPTH || e_deq);
    e_pay   = (m_q.size() != 0) ? m_q[0].pl : 32'h0;
  endtask

  task automatic model_commit();
    if (!rstn) begin
      m_q.delete(); m_stall = 0;
    end else if (bus.flush_req) begin
      m_q.delete();
    end else begin
      if (m_q.size() != 0 && !e_deq && m_stall < SMAX) m_stall++;
      if (e_deq) void'(m_q.pop_front());
      if (bus.id_i_valid && e_ready) m_q.push_back({bus.id_i_chan, bus.id_i_payload});
    end
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic settle();
    #2;
    model_eval();
  endtask

  task automatic drive(input logic v, input logic [2:0] ch, input logic [31:0] pl,
                       input logic cond, input logic [2:0] rdy, input logic fl);
    bus.id_i_valid = v; bus.id_i_chan = ch; bus.id_i_payload = pl;
    bus.disp_condition = cond; bus.disp_ready = rdy; bus.flush_req = fl;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    drive(0, 3'b001, 0, 0, 3'b000, 0);
    tick(); tick();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    settle();
    n_chk++; if (bus.disp_valid !== 3'b000) $display("FAIL reset_valid got=%b exp=000", bus.disp_valid); else n_pass++;
    n_chk++; if (bus.longi_disp !== 1'b0) $display("FAIL reset_longi got=%b exp=0", bus.longi_disp); else n_pass++;
    n_chk++; if (bus.disp_count !== 3'd0) $display("FAIL reset_count got=%0d exp=0", bus.disp_count); else n_pass++;
    n_chk++; if (bus.id_i_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", bus.id_i_ready); else n_pass++;
    n_chk++; if (bus.disp_stall_cnt !== 4'd0) $display("FAIL reset_stall got=%0d exp=0", bus.disp_stall_cnt); else n_pass++;
    tick();
  endtask

  task automatic test_fill_drain();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 3'b001, 32'h10 + i, 1, 3'b000, 0);
      settle();
      n_chk++; if (bus.id_i_ready !== 1'b1) $display("FAIL fill_ready[%0d] got=%b exp=1", i, bus.id_i_ready); else n_pass++;
      tick();
    end
    drive(1, 3'b001, 32'h99, 1, 3'b000, 0);
    settle();
    n_chk++; if (bus.id_i_ready !== 1'b0) $display("FAIL full_ready got=%b exp=0", bus.id_i_ready); else n_pass++;
    n_chk++; if (bus.disp_count !== 3'd4) $display("FAIL full_count got=%0d exp=4", bus.disp_count); else n_pass++;
    tick();
    drive(0, 3'b001, 0, 1, 3'b001, 0);
    for (int i = 0; i < 4; i++) begin
      settle();
      n_chk++; if (bus.disp_valid !== 3'b001) $display("FAIL drain_valid[%0d] got=%b exp=001", i, bus.disp_valid); else n_pass++;
      n_chk++; if (bus.disp_payload !== 32'h10 + i) $display("FAIL drain_pay[%0d] got=%h exp=%h", i, bus.disp_payload, 32'h10 + i); else n_pass++;
      n_chk++; if (bus.disp_count !== 3'(4 - i)) $display("FAIL drain_count[%0d] got=%0d exp=%0d", i, bus.disp_count, 4 - i); else n_pass++;
      tick();
    end
    settle();
    n_chk++; if (bus.disp_count !== 3'd0) $display("FAIL drained_count got=%0d exp=0", bus.disp_count); else n_pass++;
    n_chk++; if (bus.disp_valid !== 3'b000) $display("FAIL drained_valid got=%b exp=000", bus.disp_valid); else n_pass++;
    tick();
  endtask

  task automatic test_full_enq_deq();
    logic [31:0] exp;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 3'b001, 32'h20 + i, 1, 3'b000, 0);
      tick();
    end
    for (int i = 0; i < 6; i++) begin
      drive(1, 3'b001, 32'h30 + i, 1, 3'b001, 0);
      settle();
      exp = (i < 4) ? 32'h20 + i : 32'h30 + (i - 4);
      n_chk++; if (bus.id_i_ready !== 1'b1) $display("FAIL fullbb_ready[%0d] got=%b exp=1", i, bus.id_i_ready); else n_pass++;
      n_chk++; if (bus.disp_count !== 3'd4) $display("FAIL fullbb_count[%0d] got=%0d exp=4", i, bus.disp_count); else n_pass++;
      n_chk++; if (bus.disp_payload !== exp) $display("FAIL fullbb_pay[%0d] got=%h exp=%h", i, bus.disp_payload, exp); else n_pass++;
      tick();
    end
    drive(0, 3'b001, 0, 1, 3'b001, 0);
    for (int i = 0; i < 4; i++) begin
      settle();
      n_chk++; if (bus.disp_payload !== 32'h32 + i) $display("FAIL wrap_pay[%0d] got=%h exp=%h", i, bus.disp_payload, 32'h32 + i); else n_pass++;
      tick();
    end
  endtask

  task automatic test_hazard_stall();
    do_reset();
    drive(1, 3'b010, 32'hA5, 0, 3'b000, 0);
    tick();
    drive(0, 3'b001, 0, 0, 3'b010, 0);
    for (int i = 0; i < 5; i++) begin
      settle();
      n_chk++; if (bus.disp_valid !== 3'b000) $display("FAIL hazard_valid[%0d] got=%b exp=000", i, bus.disp_valid); else n_pass++;
      tick();
    end
    settle();
    n_chk++; if (bus.disp_stall_cnt !== 4'd5) $display("FAIL hazard_stall got=%0d exp=5", bus.disp_stall_cnt); else n_pass++;
    bus.disp_condition = 1'b1;
    settle();
    n_chk++; if (bus.disp_valid !== 3'b010) $display("FAIL hazard_go_valid got=%b exp=010", bus.disp_valid); else n_pass++;
    n_chk++; if (bus.longi_disp !== 1'b1) $display("FAIL hazard_go_longi got=%b exp=1", bus.longi_disp); else n_pass++;
    tick();
    settle();
    n_chk++; if (bus.longi_disp !== 1'b0) $display("FAIL hazard_after_longi got=%b exp=0", bus.longi_disp); else n_pass++;
    n_chk++; if (bus.disp_stall_cnt !== 4'd5) $display("FAIL hazard_after_stall got=%0d exp=5", bus.disp_stall_cnt); else n_pass++;
    tick();
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 3'b001, 32'h40 + i, 0, 3'b000, 0);
      tick();
    end
    drive(1, 3'b100, 32'hFF, 1, 3'b111, 1);
    settle();
    n_chk++; if (bus.disp_valid !== 3'b000) $display("FAIL flush_valid got=%b exp=000", bus.disp_valid); else n_pass++;
    n_chk++; if (bus.id_i_ready !== 1'b0) $display("FAIL flush_ready got=%b exp=0", bus.id_i_ready); else n_pass++;
    tick();
    drive(0, 3'b001, 0, 1, 3'b111, 0);
    settle();
    n_chk++; if (bus.disp_count !== 3'd0) $display("FAIL flush_count got=%0d exp=0", bus.disp_count); else n_pass++;
    n_chk++; if (bus.disp_valid !== 3'b000) $display("FAIL flush_after_valid got=%b exp=000", bus.disp_valid); else n_pass++;
    n_chk++; if (bus.disp_stall_cnt !== 4'd2) $display("FAIL flush_keeps_stall got=%0d exp=2", bus.disp_stall_cnt); else n_pass++;
    drive(1, 3'b001, 32'h50, 1, 3'b001, 0);
    tick();
    drive(0, 3'b001, 0, 1, 3'b001, 0);
    settle();
    n_chk++; if (bus.disp_payload !== 32'h50) $display("FAIL flush_next_pay got=%h exp=00000050", bus.disp_payload); else n_pass++;
    n_chk++; if (bus.disp_count !== 3'd1) $display("FAIL flush_next_count got=%0d exp=1", bus.disp_count); else n_pass++;
    tick();
  endtask

  task automatic test_longi();
    do_reset();
    drive(1, 3'b001, 32'h1, 0, 3'b000, 0); tick();
    drive(1, 3'b100, 32'h2, 0, 3'b000, 0); tick();
    drive(0, 3'b001, 0, 1, 3'b111, 0);
    settle();
    n_chk++; if (bus.longi_disp !== 1'b0) $display("FAIL longi_com got=%b exp=0", bus.longi_disp); else n_pass++;
    n_chk++; if (bus.disp_valid !== 3'b001) $display("FAIL longi_com_valid got=%b exp=001", bus.disp_valid); else n_pass++;
    tick();
    settle();
    n_chk++; if (bus.longi_disp !== 1'b1) $display("FAIL longi_mdv got=%b exp=1", bus.longi_disp); else n_pass++;
    n_chk++; if (bus.disp_valid !== 3'b100) $display("FAIL longi_mdv_valid got=%b exp=100", bus.disp_valid); else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1, 3'b001, 32'h60, 0, 3'b000, 0); tick();
    drive(1, 3'b010, 32'h61, 0, 3'b000, 0); tick();
    drive(0, 3'b001, 0, 0, 3'b000, 0);
    for (int i = 0; i < 6; i++) tick();
    settle();
    n_chk++; if (bus.disp_stall_cnt !== 4'd7) $display("FAIL mid_pre_stall got=%0d exp=7", bus.disp_stall_cnt); else n_pass++;
    n_chk++; if (bus.disp_count !== 3'd2) $display("FAIL mid_pre_count got=%0d exp=2", bus.disp_count); else n_pass++;
    rstn = 1'b0; tick(); rstn = 1'b1;
    drive(0, 3'b001, 0, 1, 3'b111, 0);
    settle();
    n_chk++; if (bus.disp_count !== 3'd0) $display("FAIL mid_count got=%0d exp=0", bus.disp_count); else n_pass++;
    n_chk++; if (bus.disp_stall_cnt !== 4'd0) $display("FAIL mid_stall got=%0d exp=0", bus.disp_stall_cnt); else n_pass++;
    n_chk++; if (bus.id_i_ready !== 1'b1) $display("FAIL mid_ready got=%b exp=1", bus.id_i_ready); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      settle();
      n_chk++; if (bus.disp_valid !== 3'b000 || bus.longi_disp !== 1'b0)
        $display("FAIL mid_nodisp[%0d] got=%b/%b exp=000/0", i, bus.disp_valid, bus.longi_disp); else n_pass++;
      tick();
    end
  endtask

  task automatic test_saturation();
    do_reset();
    drive(1, 3'b100, 32'h70, 0, 3'b000, 0); tick();
    drive(0, 3'b001, 0, 1, 3'b000, 0);
    for (int i = 0; i < 20; i++) tick();
    settle();
    n_chk++; if (bus.disp_stall_cnt !== 4'd15) $display("FAIL stall_sat got=%0d exp=15", bus.disp_stall_cnt); else n_pass++;
    tick();
  endtask

  task automatic test_random();
    int errs = 0;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rstn = ($urandom_range(0, 79) != 0);
      drive($urandom_range(0, 3) != 0, 3'(1 << $urandom_range(0, 2)), $urandom,
            $urandom_range(0, 3) != 0, 3'($urandom), $urandom_range(0, 19) == 0);
      settle();
      n_chk++;
      if (bus.disp_valid !== e_valid || bus.id_i_ready !== e_ready || bus.longi_disp !== e_longi ||
          bus.disp_count !== 3'(m_q.size()) || bus.disp_stall_cnt !== 4'(m_stall) ||
          (e_valid != 0 && bus.disp_payload !== e_pay)) begin
        if (errs < 10)
          $display("FAIL rand[%0d] got v=%b r=%b l=%b n=%0d s=%0d p=%h exp v=%b r=%b l=%b n=%0d s=%0d p=%h", c,
                   bus.disp_valid, bus.id_i_ready, bus.longi_disp, bus.disp_count, bus.disp_stall_cnt, bus.disp_payload,
                   e_valid, e_ready, e_longi, m_q.size(), m_stall, e_pay);
        errs++;
      end else n_pass++;
      tick();
    end
    rstn = 1'b1;
  endtask

  initial begin
    m_stall = 0;
    rstn = 1'b0;
    drive(0, 3'b001, 0, 0, 3'b000, 0);
    test_reset();
    test_fill_drain();
    test_full_enq_deq();
    test_hazard_stall();
    test_flush();
    test_longi();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
